// File: rtl/ddr5_cmd_scheduler_pkg.sv
// ============================================================================
// Module  : ddr5_cmd_scheduler_pkg
// Brief   : Shared types, timing defaults and address decode for the scheduler
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package ddr5_cmd_scheduler_pkg;

    localparam int c_T_RCD_DEF     = 39;
    localparam int c_T_RP_DEF      = 39;
    localparam int c_T_CL_DEF      = 40;
    localparam int c_T_CWL_DEF     = 38;
    localparam int c_T_BURST_DEF   = 8;
    localparam int c_NUM_BANKS_DEF = 32;
    localparam int c_BANK_IDX_W    = 5;

    typedef enum logic [2:0] {
        CMD_NOP = 3'd0,
        CMD_ACT = 3'd1,
        CMD_RD  = 3'd2,
        CMD_WR  = 3'd3,
        CMD_PRE = 3'd4
    } cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_CHECK     = 3'd1,
        ST_PRE       = 3'd2,
        ST_WAIT_RP   = 3'd3,
        ST_ACT       = 3'd4,
        ST_WAIT_RCD  = 3'd5,
        ST_COL       = 3'd6,
        ST_WAIT_DATA = 3'd7
    } sched_state_t;

    typedef struct packed {
        logic [63:0] cpu_cyc;
        logic [3:0]  core;
        logic [1:0]  opn;
        logic [33:0] addr;
    } din_t;

    typedef struct packed {
        logic [15:0] row;
        logic [2:0]  bg;
        logic [1:0]  bank;
        logic [9:0]  col;
        logic [4:0]  bank_idx;
    } dec_addr_t;

    // Channel bit addr[6] and byte offset addr[1:0] are not part of the mapping.
    function automatic dec_addr_t decode_addr(input logic [33:0] addr);
        dec_addr_t d;
        d.row      = addr[33:18];
        d.bank     = addr[11:10];
        d.bg       = addr[9:7];
        d.col      = {addr[17:12], addr[5:2]};
        d.bank_idx = {addr[9:7], addr[11:10]};
        return d;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ddr5_cmd_scheduler_bank_table.sv
// ============================================================================
// Module  : ddr5_bank_table
// Brief   : Per-bank open bit and open-row table with combinational lookup
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr5_bank_table #(
    parameter int NUM_BANKS = 32,
    parameter int IDX_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] lookup_idx,
    input  logic [15:0]      lookup_row,
    output logic             lookup_open,
    output logic             lookup_hit,
    input  logic             set_en,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [15:0]      set_row,
    input  logic             clr_en,
    input  logic [IDX_W-1:0] clr_idx
);

    logic        r_open [NUM_BANKS];
    logic [15:0] r_row  [NUM_BANKS];

    generate
        for (genvar gi = 0; gi < NUM_BANKS; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_open[gi] <= 1'b0;
                    r_row[gi]  <= '0;
                end else if (set_en && (set_idx == IDX_W'(gi))) begin
                    r_open[gi] <= 1'b1;
                    r_row[gi]  <= set_row;
                end else if (clr_en && (clr_idx == IDX_W'(gi))) begin
                    r_open[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign lookup_open = r_open[lookup_idx];
    assign lookup_hit  = r_open[lookup_idx] && (r_row[lookup_idx] == lookup_row);

endmodule

`default_nettype wire

// File: rtl/ddr5_cmd_scheduler.sv
// ============================================================================
// Module  : ddr5_cmd_scheduler
// Brief   : In-order open-page DDR5 command sequencer (PRE/ACT/RD/WR)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module ddr5_cmd_scheduler
    import ddr5_cmd_scheduler_pkg::*;
#(
    parameter int T_RCD     = c_T_RCD_DEF,
    parameter int T_RP      = c_T_RP_DEF,
    parameter int T_CL      = c_T_CL_DEF,
    parameter int T_CWL     = c_T_CWL_DEF,
    parameter int T_BURST   = c_T_BURST_DEF,
    parameter int NUM_BANKS = c_NUM_BANKS_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req_valid,
    input  logic [103:0] req,
    output logic         req_ready,
    output logic         cmd_valid,
    output logic [2:0]   cmd,
    output logic [2:0]   cmd_bg,
    output logic [1:0]   cmd_bank,
    output logic [15:0]  cmd_row,
    output logic [9:0]   cmd_col,
    output logic [3:0]   cmd_core,
    output logic         done,
    output logic         busy,
    output logic [63:0]  now_cyc
);

    localparam logic [15:0] c_RP_LOAD  = 16'(T_RP - 1);
    localparam logic [15:0] c_RCD_LOAD = 16'(T_RCD - 1);
    localparam logic [15:0] c_RD_LOAD  = 16'(T_CL + T_BURST - 1);
    localparam logic [15:0] c_WR_LOAD  = 16'(T_CWL + T_BURST - 1);

    sched_state_t r_state;
    sched_state_t w_state_next;
    din_t         w_req;
    dec_addr_t    w_dec;

    logic [63:0] r_now;
    logic [15:0] r_cnt;
    logic [33:0] r_addr;
    logic [1:0]  r_opn;
    logic [3:0]  r_core;
    logic [2:0]  r_cmd_bg;
    logic [1:0]  r_cmd_bank;
    logic [15:0] r_cmd_row;
    logic [9:0]  r_cmd_col;
    logic [3:0]  r_cmd_core;

    logic w_accept;
    logic w_is_wr;
    logic w_bank_open;
    logic w_bank_hit;
    logic w_wait_last;
    logic w_cmd_load;
    logic w_tbl_set;
    logic w_tbl_clr;
    logic w_done;
    logic w_cmd_valid;
    cmd_t w_cmd;

    assign w_req    = din_t'(req);
    assign w_dec    = decode_addr(r_addr);
    assign w_is_wr  = (r_opn == 2'd1);
    assign w_accept = (r_state == ST_IDLE) && req_valid && !rst && (w_req.cpu_cyc <= r_now);

    // Exiting at cnt<=1 places ACT/RD exactly tRP/tRCD after the issuing cycle.
    assign w_wait_last = (r_cnt <= 16'd1);

    ddr5_bank_table #(
        .NUM_BANKS (NUM_BANKS),
        .IDX_W     (c_BANK_IDX_W)
    ) u_bank_table (
        .clk         (clk),
        .rst         (rst),
        .lookup_idx  (w_dec.bank_idx),
        .lookup_row  (w_dec.row),
        .lookup_open (w_bank_open),
        .lookup_hit  (w_bank_hit),
        .set_en      (w_tbl_set),
        .set_idx     (w_dec.bank_idx),
        .set_row     (w_dec.row),
        .clr_en      (w_tbl_clr),
        .clr_idx     (w_dec.bank_idx)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            ST_IDLE:      if (w_accept) w_state_next = ST_CHECK;
            ST_CHECK: begin
                if (w_bank_hit)       w_state_next = ST_COL;
                else if (w_bank_open) w_state_next = ST_PRE;
                else                  w_state_next = ST_ACT;
            end
            ST_PRE:       w_state_next = ST_WAIT_RP;
            ST_WAIT_RP:   if (w_wait_last) w_state_next = ST_ACT;
            ST_ACT:       w_state_next = ST_WAIT_RCD;
            ST_WAIT_RCD:  if (w_wait_last) w_state_next = ST_COL;
            ST_COL:       w_state_next = ST_WAIT_DATA;
            ST_WAIT_DATA: if (r_cnt == 16'd0) w_state_next = ST_IDLE;
            default:      w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_cmd       = CMD_NOP;
        w_cmd_valid = 1'b0;
        w_tbl_set   = 1'b0;
        w_tbl_clr   = 1'b0;
        w_done      = 1'b0;
        case (r_state)
            ST_PRE: begin
                w_cmd       = CMD_PRE;
                w_cmd_valid = 1'b1;
                w_tbl_clr   = 1'b1;
            end
            ST_ACT: begin
                w_cmd       = CMD_ACT;
                w_cmd_valid = 1'b1;
                w_tbl_set   = 1'b1;
            end
            ST_COL: begin
                w_cmd       = w_is_wr ? CMD_WR : CMD_RD;
                w_cmd_valid = 1'b1;
            end
            ST_WAIT_DATA: w_done = (r_cnt == 16'd0);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_now <= '0;
        end else begin
            r_now <= r_now + 64'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else begin
            case (r_state)
                ST_PRE:  r_cnt <= c_RP_LOAD;
                ST_ACT:  r_cnt <= c_RCD_LOAD;
                ST_COL:  r_cnt <= w_is_wr ? c_WR_LOAD : c_RD_LOAD;
                ST_WAIT_RP, ST_WAIT_RCD, ST_WAIT_DATA: begin
                    if (r_cnt != 16'd0) r_cnt <= r_cnt - 16'd1;
                end
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_addr <= '0;
            r_opn  <= '0;
            r_core <= '0;
        end else if (w_accept) begin
            r_addr <= w_req.addr;
            r_opn  <= w_req.opn;
            r_core <= w_req.core;
        end
    end

    // Address fields change only on entry to a command state, so they hold otherwise.
    assign w_cmd_load = (w_state_next == ST_PRE) || (w_state_next == ST_ACT) ||
                        (w_state_next == ST_COL);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cmd_bg   <= '0;
            r_cmd_bank <= '0;
            r_cmd_row  <= '0;
            r_cmd_col  <= '0;
            r_cmd_core <= '0;
        end else if (w_cmd_load) begin
            r_cmd_bg   <= w_dec.bg;
            r_cmd_bank <= w_dec.bank;
            r_cmd_row  <= w_dec.row;
            r_cmd_col  <= w_dec.col;
            r_cmd_core <= r_core;
        end
    end

    assign req_ready = w_accept;
    assign cmd_valid = w_cmd_valid;
    assign cmd       = w_cmd;
    assign cmd_bg    = r_cmd_bg;
    assign cmd_bank  = r_cmd_bank;
    assign cmd_row   = r_cmd_row;
    assign cmd_col   = r_cmd_col;
    assign cmd_core  = r_cmd_core;
    assign done      = w_done;
    assign busy      = (r_state != ST_IDLE);
    assign now_cyc   = r_now;

endmodule

`default_nettype wire

// File: tb/tb_ddr5_cmd_scheduler.sv
// ============================================================================
// Module  : tb_ddr5_cmd_scheduler
// Brief   : Scoreboard bench: expected command/ready/done events vs DUT monitor
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_ddr5_cmd_scheduler;

    localparam int c_T_RCD   = 39;
    localparam int c_T_RP    = 39;
    localparam int c_T_CL    = 40;
    localparam int c_T_CWL   = 38;
    localparam int c_T_BURST = 8;

    localparam int c_K_RDY  = 8;
    localparam int c_K_DONE = 9;
    localparam int c_HIT  = 0;
    localparam int c_MISS = 1;
    localparam int c_CONF = 2;

    typedef struct {
        string       nm;
        int          kind;
        logic [63:0] cyc;
        int          bg;
        int          bank;
        int          row;
        int          col;
        int          core;
    } ev_t;

    logic         clk;
    logic         rst;
    logic         req_valid;
    logic [103:0] req;
    logic         req_ready;
    logic         cmd_valid;
    logic [2:0]   cmd;
    logic [2:0]   cmd_bg;
    logic [1:0]   cmd_bank;
    logic [15:0]  cmd_row;
    logic [9:0]   cmd_col;
    logic [3:0]   cmd_core;
    logic         done;
    logic         busy;
    logic [63:0]  now_cyc;

    logic [63:0]  tb_cyc;
    ev_t          exp_q[$];
    int           compared;
    int           mismatched;

    ddr5_cmd_scheduler dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req       (req),
        .req_ready (req_ready),
        .cmd_valid (cmd_valid),
        .cmd       (cmd),
        .cmd_bg    (cmd_bg),
        .cmd_bank  (cmd_bank),
        .cmd_row   (cmd_row),
        .cmd_col   (cmd_col),
        .cmd_core  (cmd_core),
        .done      (done),
        .busy      (busy),
        .now_cyc   (now_cyc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) tb_cyc <= 64'd0;
        else     tb_cyc <= tb_cyc + 64'd1;
    end

    function automatic void push_ev(input string nm, input int kind, input logic [63:0] cyc,
                                    input int bg, input int bank, input int row,
                                    input int col, input int core);
        ev_t e;
        e.nm = nm; e.kind = kind; e.cyc = cyc; e.bg = bg; e.bank = bank;
        e.row = row; e.col = col; e.core = core;
        exp_q.push_back(e);
    endfunction

    task automatic check_ev(input int kind);
        ev_t e;
        bit  ok;
        compared++;
        if (exp_q.size() == 0) begin
            mismatched++;
            $display("FAIL unexpected_event: got kind=%0d at cyc=%0d, required no event",
                     kind, tb_cyc);
            return;
        end
        e  = exp_q.pop_front();
        ok = (e.kind == kind) && (e.cyc == tb_cyc);
        if (kind >= 1 && kind <= 4) begin
            ok = ok && (int'(cmd_bg) == e.bg) && (int'(cmd_bank) == e.bank);
            if (kind == 1) ok = ok && (int'(cmd_row) == e.row);
            if (kind == 2 || kind == 3) ok = ok && (int'(cmd_col) == e.col);
            if (kind != 4) ok = ok && (int'(cmd_core) == e.core);
        end
        if (!ok) begin
            mismatched++;
            $display("FAIL %s: got kind=%0d cyc=%0d bg=%0d bank=%0d row=%h col=%h core=%0d, required kind=%0d cyc=%0d bg=%0d bank=%0d row=%h col=%h core=%0d",
                     e.nm, kind, tb_cyc, cmd_bg, cmd_bank, cmd_row, cmd_col, cmd_core,
                     e.kind, e.cyc, e.bg, e.bank, e.row, e.col, e.core);
        end
    endtask

    // Monitor: samples well after the falling edge, clear of both clock edges.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (!rst) begin
                if (req_ready) check_ev(c_K_RDY);
                if (cmd_valid) check_ev(int'(cmd));
                if (done)      check_ev(c_K_DONE);
            end
        end
    end

    task automatic check_zero(input string nm);
        logic [105:0] v;
        v = {req_ready, cmd_valid, cmd, cmd_bg, cmd_bank, cmd_row, cmd_col, cmd_core,
             done, busy, now_cyc};
        compared++;
        if (v !== '0) begin
            mismatched++;
            $display("FAIL %s: outputs=%h, required all zero", nm, v);
        end
    endtask

    task automatic send(input string nm, input logic [33:0] addr, input logic [1:0] opn,
                        input logic [3:0] core, input logic [63:0] cpu, input int path,
                        input int bg, input int bank, input int row, input int col,
                        input bit abort);
        logic [63:0] a;
        logic [63:0] c;
        int          lat;
        int          ccmd;
        bit          got;
        compared++;
        if (now_cyc !== tb_cyc) begin
            mismatched++;
            $display("FAIL %s.now_cyc: got %0d, required %0d", nm, now_cyc, tb_cyc);
        end
        a    = (cpu > tb_cyc) ? cpu : tb_cyc;
        lat  = (opn == 2'd1) ? (c_T_CWL + c_T_BURST) : (c_T_CL + c_T_BURST);
        ccmd = (opn == 2'd1) ? 3 : 2;
        push_ev({nm, ".ready"}, c_K_RDY, a, 0, 0, 0, 0, 0);
        c = a + 64'd2;
        if (path == c_CONF) begin
            push_ev({nm, ".pre"}, 4, c, bg, bank, row, col, int'(core));
            c = c + 64'(c_T_RP);
        end
        if (path != c_HIT) begin
            push_ev({nm, ".act"}, 1, c, bg, bank, row, col, int'(core));
            c = c + 64'(c_T_RCD);
        end
        if (!abort) begin
            push_ev({nm, ".col"}, ccmd, c, bg, bank, row, col, int'(core));
            push_ev({nm, ".done"}, c_K_DONE, c + 64'(lat), 0, 0, 0, 0, 0);
        end
        req       = {cpu, core, opn, addr};
        req_valid = 1'b1;
        got       = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            #1;
            if (req_ready) begin
                got = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!got) begin
            compared++;
            mismatched++;
            $display("FAIL %s.ready_timeout: got no req_ready, required one", nm);
        end
        @(negedge clk);
        req_valid = 1'b0;
        if (abort) begin
            repeat (9) @(negedge clk);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            #1;
            check_zero({nm, ".after_reset"});
            repeat (80) @(negedge clk);
        end else begin
            got = 1'b0;
            for (int i = 0; i < 300; i++) begin
                #1;
                if (done) begin
                    got = 1'b1;
                    break;
                end
                @(negedge clk);
            end
            if (!got) begin
                compared++;
                mismatched++;
                $display("FAIL %s.done_timeout: got no done, required one", nm);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req        = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #1;
        check_zero("reset_state");
        rst = 1'b0;
        @(negedge clk);

        send("cold_read",  34'h0_0004_0284, 2'd0, 4'd3,  64'd0, c_MISS, 5, 0, 16'h0001, 10'h001, 1'b0);
        send("page_hit",   34'h0_0004_228C, 2'd1, 4'd2,  64'd0, c_HIT,  5, 0, 16'h0001, 10'h023, 1'b0);
        send("row_conf",   34'h0_0008_0294, 2'd2, 4'd1,  64'd0, c_CONF, 5, 0, 16'h0002, 10'h005, 1'b0);
        send("bank0_open", 34'h0_0014_0000, 2'd0, 4'd0,  64'd0, c_MISS, 0, 0, 16'h0005, 10'h000, 1'b0);
        send("bank_indep", 34'h0_001C_00C3, 2'd3, 4'd4,  64'd0, c_MISS, 1, 0, 16'h0007, 10'h000, 1'b0);
        send("bank0_hit",  34'h0_0017_F03C, 2'd1, 4'd5,  64'd0, c_HIT,  0, 0, 16'h0005, 10'h3FF, 1'b0);
        send("max_row",    34'h3_FFFC_0F80, 2'd0, 4'd15, 64'd0, c_MISS, 7, 3, 16'hFFFF, 10'h000, 1'b0);
        send("abort",      34'h0_0024_0500, 2'd0, 4'd6,  64'd0, c_MISS, 2, 1, 16'h0009, 10'h000, 1'b1);

        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL abort.pending: got %0d events outstanding, required 0", exp_q.size());
            exp_q.delete();
        end

        send("post_reset", 34'h0_0024_0500, 2'd0, 4'd6,  64'd0, c_MISS, 2, 1, 16'h0009, 10'h000, 1'b0);
        send("bank0_cold", 34'h0_0014_0000, 2'd0, 4'd0,  64'd0, c_MISS, 0, 0, 16'h0005, 10'h000, 1'b0);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        while (tb_cyc < 64'd10) @(negedge clk);
        send("time_gate",  34'h0_0004_0284, 2'd0, 4'd7, 64'd500, c_MISS, 5, 0, 16'h0001, 10'h001, 1'b0);

        repeat (5) @(negedge clk);
        compared++;
        if (exp_q.size() != 0) begin
            mismatched++;
            $display("FAIL end.pending: got %0d events outstanding, required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/ddr5_cmd_scheduler.md
Name: ddr5_cmd_scheduler

Overview:
- Pops requests one at a time from the 16-entry request queue and decodes each address into row/bank/column fields.
- Sequences each request into DDR5 commands (PRE, ACT, RD, WR) under an open-page policy. Tracks the open row per bank and enforces tRP, tRCD and CAS timing with down-counters.
- Sits between the request queue and the DRAM command trace/PHY model; single channel, in-order service.

Parameters:
- T_RCD, 39, clk cycles from ACT to RD/WR on the same bank
- T_RP, 39, clk cycles from PRE to ACT on the same bank
- T_CL, 40, clk cycles from RD to data start
- T_CWL, 38, clk cycles from WR to data start
- T_BURST, 8, clk cycles of data burst (BL16)
- NUM_BANKS, 32, bank groups x banks (8 x 4)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- req_valid  in  1  queue head valid (queue not empty)
- req  in  104  dIn_t {cpu_cyc[63:0], core[3:0], opn[1:0], addr[33:0]}
- req_ready  out  1  one-cycle dequeue strobe
- cmd_valid  out  1  command issued this cycle
- cmd  out  3  cmd_t: NOP=0, ACT=1, RD=2, WR=3, PRE=4
- cmd_bg  out  3  bank group
- cmd_bank  out  2  bank
- cmd_row  out  16  row (valid on ACT)
- cmd_col  out  10  column (valid on RD/WR)
- cmd_core  out  4  requesting core
- done  out  1  pulse when the request's data burst completes
- busy  out  1  FSM not in IDLE
- now_cyc  out  64  internal cycle counter

Behaviour:
- Reset: all outputs 0, cmd=NOP, FSM=IDLE, all bank-open bits cleared, now_cyc=0, counters=0.
- now_cyc increments every cycle from reset, 64-bit wrap.
- Address decode:
  - row = addr[33:18]
  - high_col = addr[17:12]
  - bank = addr[11:10]
  - bg = addr[9:7]
  - channel = addr[6], ignored
  - low_col = addr[5:2]
  - col = {high_col, low_col}
  - addr[1:0] ignored
  - bank index = {bg, bank}
- opn decode: 1 = write; 0, 2 and 3 = read.
- IDLE:
  - Stays in IDLE while req_valid=0 or req.cpu_cyc > now_cyc.
  - Otherwise asserts req_ready for exactly 1 cycle, latches req into a holding register, and goes to CHECK.
- CHECK (1 cycle):
  - Bank open with matching row: go to COL (page hit).
  - Bank open with a different row: go to PRE.
  - Bank closed: go to ACT.
- PRE:
  - Issues cmd=PRE for 1 cycle and clears the bank-open bit.
  - Loads cnt=T_RP-1, then goes to WAIT_RP.
- WAIT_RP: decrements cnt; at cnt=0 goes to ACT.
- ACT:
  - Issues ACT with row, sets the bank-open bit, and writes the row into the open-row table.
  - Loads cnt=T_RCD-1, then goes to WAIT_RCD.
- WAIT_RCD: decrements cnt; at 0 goes to COL.
- COL:
  - Issues RD or WR with col.
  - Loads cnt = (T_CL or T_CWL) + T_BURST - 1, then goes to WAIT_DATA.
- WAIT_DATA: decrements cnt; at 0 pulses done for 1 cycle and returns to IDLE.
- The next request cannot be accepted in the done cycle. Earliest req_ready is the cycle after done.
- cmd_valid=1 exactly on cycles issuing PRE/ACT/RD/WR. In all other cycles cmd=NOP and the address fields hold their last values.
- Exactly one command per cycle; no pipelining across requests.
- Rows stay open after service (open-page); nothing closes them except a conflicting request or reset.
- Reset mid-sequence: returns to IDLE next cycle and clears the bank table. A held request is discarded and gets no done.
- req_valid dropping while not in IDLE has no effect.
- cpu_cyc equal to now_cyc is eligible in that same cycle.

Decomposition:
- Shared package (extend the existing structures package):
  - cmd_t enum
  - sched_state_t enum
  - decoded-address struct and decode function (the authoritative mapping above)
  - timing default localparams
- Sub-module ddr5_bank_table:
  - 32 entries of {open, row[15:0]}
  - combinational lookup by bank index returning hit/open
  - synchronous set/clear with rst clear

Test Plan:
- Cold read:
  - Stimulus: addr=0x0_0004_0284, opn=0, cpu_cyc=0.
  - Required: req_ready at cycle 1, ACT bg=5 bank=0 row=0x0001 col=0x001 core as given, RD exactly T_RCD cycles later, done T_CL+T_BURST cycles after RD, no PRE.
- Page hit:
  - Stimulus: the same row and bank as the cold read, different col, opn=1.
  - Required: WR issued 1 cycle after CHECK with no ACT/PRE; done T_CWL+T_BURST cycles after WR.
- Row conflict:
  - Stimulus: the same bg/bank as the cold read, row=0x0002.
  - Required: PRE, ACT exactly T_RP cycles later with row 0x0002, RD T_RCD cycles after that.
- Time gating:
  - Stimulus: cpu_cyc=500 presented at now_cyc=10.
  - Required: req_ready stays 0 until now_cyc=500, then asserts in that cycle.
- Bank independence:
  - Stimulus: open bg=0 bank=0 row=5, then access bg=1 bank=0 row=7.
  - Required: ACT without PRE; a third request to bg=0 bank=0 row=5 is a hit.
- Reset mid-op:
  - Stimulus: assert rst during WAIT_RCD.
  - Required: no done, all outputs 0 next cycle; the next request to that bank takes the ACT path, not a hit.
